serial_adder_subtractor_ctrl: RTL
=================================

// Module: serial_adder_subtractor_ctrl
// PURPOSE
//  Bit-serial WIDTH-bit adder/subtractor sequencer built around one instance of the team's one-bit adder/subtractor cell.
//  Loads operands on start and feeds the cell one bit per clock, LSB first.
//  Holds the carry in a flip-flop between bits and shifts the cell's sum bit into a result register.
//  Sits between the operand source (testbench or top-level lab FSM) and the result consumer.
//  It is a sequential, area-minimal alternative to the ripple four-bit adder/subtractor.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>= 2); bit counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      request; sampled only in IDLE
//  A         in   WIDTH  operand A, captured on accepted start
//  B         in   WIDTH  operand B, captured on accepted start
//  Sel       in   1      0 = A+B, 1 = A-B (two's complement); captured on accepted start
//  busy      out  1      high while in RUN
//  done      out  1      one-cycle pulse; Result/Cout/Overflow are valid from this cycle
//  Result    out  WIDTH  sum/difference, registered
//  Cout      out  1      carry out of MSB (for subtract: 1 = no borrow)
//  Overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: async on rst_n=0. State goes to IDLE. busy, done, Result, Cout, Overflow, shift registers, carry FF and counter all go to 0.
//  - FSM has three states:
//    IDLE -> RUN on start=1 (accept edge).
//    RUN -> RUN while count < WIDTH-1.
//    RUN -> DONE on the edge that processes bit WIDTH-1.
//    DONE -> IDLE unconditionally.
//  - Accept edge: opA<=A, opB<=B, sel_q<=Sel, carry<=Sel (the +1 of two's complement), count<=0.
//  - RUN, each cycle: the cell sees opA[0], opB[0], sel_q, carry. At the edge:
//    - shift the cell's S into the result shift register from the MSB side;
//    - carry <= cell Cout;
//    - opA and opB shift right by 1;
//    - count++.
//    On the bit WIDTH-1 edge, also save the old carry as carry-into-MSB.
//  - RUN->DONE edge: copy Result <= shift register with S of bit WIDTH-1 included; Cout <= cell Cout; Overflow <= carry-into-MSB ^ cell Cout.
//  - Outputs are updated only at that edge and hold until the next completed operation.
//  - Latency: start sampled at edge 0 -> busy=1 during cycles 1..WIDTH -> done=1 during cycle WIDTH+1. Next start is accepted at the earliest at edge WIDTH+2 (IDLE).
//  - start while RUN or DONE: ignored, not queued. start held high in IDLE: a new operation starts each time IDLE is reached.
//  - A, B and Sel changing during RUN have no effect.
//  - Reset mid-RUN: aborts immediately; no done pulse; outputs are 0.
//  - Clock period must exceed the cell's worst-case propagation (>= 50 ns with unit gate delays of 10 ns).
//  - Wrap-around: Result is modulo 2^WIDTH; the carry beyond Cout is discarded.
// TESTING
//  1. WIDTH=4, A=0011 B=0101 Sel=0 -> done at cycle 5, Result=1000 Cout=0 Overflow=1.
//  2. A=0111 B=0010 Sel=1 -> Result=0101 Cout=1 Overflow=0; busy high exactly 4 cycles.
//  3. A=0010 B=0111 Sel=1 -> Result=1011 Cout=0 Overflow=0.
//  4. A=1000 B=0001 Sel=1 -> Result=0111 Cout=1 Overflow=1.
//  5. start pulsed again at cycle 2 of a run with different operands -> ignored; first result is unchanged; exactly one done pulse.
//  6. rst_n low at cycle 2 of a run (A=1111 B=0001 Sel=0) -> all outputs 0 immediately, no done. After release a fresh start gives Result=0000 Cout=1 Overflow=0.

Source files
------------

// File: rtl/serial_adder_subtractor_ctrl_if.sv
// Operand/result bundle for the bit-serial adder/subtractor sequencer.
//   master : drives start, A, B, Sel; observes busy, done, Result, Cout, Overflow
//   slave  : the sequencer side of the same signals
interface serial_adder_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Cout;
  logic             Overflow;

  modport master (
    output start, A, B, Sel,
    input  busy, done, Result, Cout, Overflow
  );

  modport slave (
    input  start, A, B, Sel,
    output busy, done, Result, Cout, Overflow
  );
endinterface

// File: rtl/serial_adder_subtractor_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor sequencer.
// Captures A/B/Sel on an accepted start, then feeds one full adder/subtractor
// cell one bit per clock (LSB first), keeping the carry in a flop and shifting
// the sum bit into a result shift register from the MSB side.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of serial_adder_subtractor_ctrl_if
//            start/A/B/Sel in; busy, done (1-cycle pulse), Result, Cout,
//            Overflow out, all registered
module serial_adder_subtractor_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_adder_subtractor_ctrl_if.slave bus
);

  localparam int unsigned    CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] opa_q,      opa_d;
  logic [WIDTH-1:0] opb_q,      opb_d;
  logic [WIDTH-1:0] sr_q,       sr_d;
  logic             sel_q,      sel_d;
  logic             carry_q,    carry_d;
  logic [CW-1:0]    count_q,    count_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;

  // One-bit adder/subtractor cell: B is inverted when subtracting; the +1 of
  // two's complement comes from the carry flop being preset to Sel.
  logic cell_b;
  logic cell_s;
  logic cell_co;

  always_comb begin
    cell_b  = opb_q[0] ^ sel_q;
    cell_s  = opa_q[0] ^ cell_b ^ carry_q;
    cell_co = (opa_q[0] & cell_b) | (opa_q[0] & carry_q) | (cell_b & carry_q);
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sr_d       = sr_q;
    sel_d      = sel_q;
    carry_d    = carry_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          opa_d   = bus.A;
          opb_d   = bus.B;
          sel_d   = bus.Sel;
          carry_d = bus.Sel;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        sr_d    = {cell_s, sr_q[WIDTH-1:1]};
        carry_d = cell_co;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          // carry_q here is the carry into the MSB, so overflow needs no
          // separate holding flop.
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          result_d   = {cell_s, sr_q[WIDTH-1:1]};
          cout_d     = cell_co;
          overflow_d = carry_q ^ cell_co;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      sr_q       <= '0;
      sel_q      <= 1'b0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      sr_q       <= sr_d;
      sel_q      <= sel_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Result   = result_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = overflow_q;

endmodule
